sprite_line_fetch: RTL and testbench
====================================

// Module: sprite_line_fetch
// PURPOSE
//  Read-side client of the sprite ROMs (1-cycle registered read: addr at edge N, q valid after edge N+1).
//  In horizontal blanking, fetches one sprite row into a local line buffer; in active video, emits the
//  palette index for the current draw_x. Sits between the VGA timing/position logic and the colour mapper.
// PARAMETERS
//  SPR_W   26  sprite width in pixels (columns per row)
//  SPR_H   32  sprite height in rows
//  ADDR_W  10  ROM address width; ROM addr = row*SPR_W + col
//  PIX_W   3   palette index width; index 0 = transparent
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous active-low reset
//  line_start  in   1       1-cycle pulse at start of hblank; request fetch for next_y
//  next_y      in   10      scanline about to be drawn
//  spr_x       in   10      sprite left column (screen px)
//  spr_y       in   10      sprite top row (screen px)
//  flip        in   1       horizontal mirror, sampled at line_start (only with SPRITE_FLIP_EN)
//  draw_x      in   10      current horizontal pixel from VGA controller
//  rom_addr    out  ADDR_W  ROM address
//  rom_q       in   PIX_W   ROM read data (1-cycle latency)
//  busy        out  1       fetch in progress
//  pix_valid   out  1       opaque sprite pixel at draw_x (registered)
//  pix_idx     out  PIX_W   palette index, 0 when !pix_valid (registered)
// BEHAVIOUR
//  Reset (async): state=IDLE; rom_addr=0, busy=0, pix_valid=0, pix_idx=0, line_valid=0, buffer contents don't-care.
//  FSM IDLE -> FETCH -> DRAIN -> IDLE.
//  IDLE: on line_start, row = {1'b0,next_y} - {1'b0,spr_y} (11-bit); clear line_valid.
//   If no borrow and row < SPR_H: latch row (and flip), col=0, go FETCH, busy=1. Else stay IDLE (line_valid=0).
//  FETCH: each cycle rom_addr = row*SPR_W + col, col++; write rom_q of previous cycle into buf[col-1]
//   (buf[SPR_W-1-(col-1)] when flipped). After col=SPR_W-1 issued, go DRAIN.
//  DRAIN: write last datum; line_valid=1, busy=0, go IDLE. busy high for exactly SPR_W+1 cycles.
//  line_start while busy: ignored; fetch in progress completes unchanged.
//  Output (1-cycle latency from draw_x): dx = {1'b0,draw_x}-{1'b0,spr_x}; pix_idx=buf[dx] and pix_valid=1
//   iff line_valid && no borrow && dx<SPR_W && buf[dx]!=0; else pix_idx=0, pix_valid=0.
//  While busy, line_valid=0 so pix_valid=0 (no stale/partial row shown).
//  rom_addr holds last value in IDLE/DRAIN. Multiply is by constant; row*SPR_W+col fits ADDR_W (asserted).
//  Reset mid-FETCH: immediate IDLE, busy=0, line_valid=0; next line_start starts cleanly.
// CONFIGURATION
//  SPRITE_FLIP_EN defined: flip port present; flip sampled at accepted line_start mirrors column writes.
//  Undefined: flip port absent; columns always stored left-to-right (buf[c] = ROM col c).
// STRUCTURE
//  sprite_pkg: SPR_W, SPR_H, PIX_W, TRANSPARENT_IDX=0, typedef enum logic[1:0] {IDLE,FETCH,DRAIN} fetch_state_t.
//  Sub-module sprite_line_buf: SPR_W x PIX_W register array, 1 sync write port, 1 async read port.
//  Top: FSM, column counter, address generator, output register.
// TESTING (bench models ROM with 1-cycle latency, mem[a] = a[2:0])
//  spr_y=100, next_y=105, line_start -> addrs 130..155 on consecutive cycles, busy 27 cycles, line_valid set.
//  after above, spr_x=200, sweep draw_x 199..226 -> pix_valid only at 200..225 where mem!=0, idx=(130+dx)&7, 1-cycle lag.
//  next_y=99 or 132 with spr_y=100 -> no FETCH, busy stays 0, pix_valid 0 for all draw_x.
//  second line_start at FETCH cycle 10 -> ignored; addresses continue to 155; busy total still 27.
//  reset_n low at FETCH cycle 5 -> busy=0, pix_valid=0 at once; new line_start fetches full row correctly.
//  SPRITE_FLIP_EN, flip=1, row 5 -> draw_x=spr_x gives mem[155]&7, draw_x=spr_x+25 gives mem[130]&7.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and ROM address helper for the sprite line fetcher.
package sprite_pkg;

  localparam int unsigned SPR_W  = 26;
  localparam int unsigned SPR_H  = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned PIX_W  = 3;

  localparam int unsigned COL_W = $clog2(SPR_W);
  localparam int unsigned ROW_W = $clog2(SPR_H);

  localparam logic [PIX_W-1:0] TRANSPARENT_IDX = '0;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;

  // Full-width address so callers can check it fits ADDR_W before truncating.
  function automatic logic [31:0] rom_addr_full(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return 32'(row) * SPR_W + 32'(col);
  endfunction

endpackage

// File: rtl/sprite_line_fetch_if.sv
// Sprite ROM read bus: address out from the fetcher, data back with one cycle of latency.
interface sprite_line_fetch_if;
  import sprite_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);

endinterface

// File: rtl/sprite_line_buf.sv
// One sprite row of palette indices: synchronous write port, asynchronous read port.
module sprite_line_buf
  import sprite_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [COL_W-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [COL_W-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [SPR_W];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < SPR_W)) begin
      mem[waddr] <= wdata;
    end
  end

  // Index range exceeds SPR_W; out-of-range reads return transparent.
  assign rdata = (32'(raddr) < SPR_W) ? mem[raddr] : TRANSPARENT_IDX;

endmodule

// File: rtl/sprite_line_fetch.sv
// Fetches one sprite row into a line buffer during hblank and emits palette indices in active video.
// Optional horizontal mirroring is enabled by defining SPRITE_FLIP_EN.
module sprite_line_fetch
  import sprite_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 line_start,
  input  logic [9:0]           next_y,
  input  logic [9:0]           spr_x,
  input  logic [9:0]           spr_y,
`ifdef SPRITE_FLIP_EN
  input  logic                 flip,
`endif
  input  logic [9:0]           draw_x,
  sprite_line_fetch_if.master  rom,
  output logic                 busy,
  output logic                 pix_valid,
  output logic [PIX_W-1:0]     pix_idx
);

  fetch_state_t      state_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              flip_q;
  logic              line_valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              pix_valid_q;
  logic [PIX_W-1:0]  pix_idx_q;

  logic              flip_in;
  logic [10:0]       row_diff;
  logic              row_hit;
  logic [31:0]       addr_full_d;
  logic              wr_en;
  logic [COL_W-1:0]  wr_col;
  logic [COL_W-1:0]  wr_idx;
  logic [10:0]       dx;
  logic              dx_hit;
  logic [PIX_W-1:0]  rd_data;

`ifdef SPRITE_FLIP_EN
  assign flip_in = flip;
`else
  assign flip_in = 1'b0;
`endif

  // Top bit of the 11-bit difference is the borrow: scanline above the sprite.
  assign row_diff = {1'b0, next_y} - {1'b0, spr_y};
  assign row_hit  = !row_diff[10] && (row_diff[9:0] < 10'(SPR_H));

  // Address register is loaded one cycle ahead so column k is on the bus in FETCH cycle k.
  always_comb begin
    addr_full_d = rom_addr_full(row_q, col_q + 1'b1);
    if (state_q == IDLE) begin
      addr_full_d = rom_addr_full(row_diff[ROW_W-1:0], '0);
    end
  end

  // ROM data trails the address by one cycle; DRAIN captures the final column.
  always_comb begin
    wr_en  = 1'b0;
    wr_col = '0;
    if (state_q == FETCH && col_q != '0) begin
      wr_en  = 1'b1;
      wr_col = col_q - 1'b1;
    end else if (state_q == DRAIN) begin
      wr_en  = 1'b1;
      wr_col = col_q;
    end
    wr_idx = flip_q ? (COL_W'(SPR_W - 1) - wr_col) : wr_col;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      flip_q       <= 1'b0;
      line_valid_q <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (line_start) begin
            line_valid_q <= 1'b0;
            if (row_hit) begin
              assert (addr_full_d < 32'(2 ** ADDR_W));
              row_q   <= row_diff[ROW_W-1:0];
              col_q   <= '0;
              flip_q  <= flip_in;
              addr_q  <= addr_full_d[ADDR_W-1:0];
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          if (col_q == COL_W'(SPR_W - 1)) begin
            state_q <= DRAIN;
          end else begin
            assert (addr_full_d < 32'(2 ** ADDR_W));
            col_q  <= col_q + 1'b1;
            addr_q <= addr_full_d[ADDR_W-1:0];
          end
        end
        DRAIN: begin
          line_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sprite_line_buf u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (rom.rom_q),
    .raddr (dx[COL_W-1:0]),
    .rdata (rd_data)
  );

  assign dx     = {1'b0, draw_x} - {1'b0, spr_x};
  assign dx_hit = !dx[10] && (dx[9:0] < 10'(SPR_W));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_q <= 1'b0;
      pix_idx_q   <= TRANSPARENT_IDX;
    end else if (line_valid_q && dx_hit && rd_data != TRANSPARENT_IDX) begin
      pix_valid_q <= 1'b1;
      pix_idx_q   <= rd_data;
    end else begin
      pix_valid_q <= 1'b0;
      pix_idx_q   <= TRANSPARENT_IDX;
    end
  end

  assign rom.rom_addr = addr_q;
  assign busy         = busy_q;
  assign pix_valid    = pix_valid_q;
  assign pix_idx      = pix_idx_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a 1-cycle ROM model where mem[a] = a[2:0].
module tb_sprite_line_fetch;
  import sprite_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             line_start;
  logic [9:0]       next_y;
  logic [9:0]       spr_x;
  logic [9:0]       spr_y;
  logic             flip;
  logic [9:0]       draw_x;
  logic             busy;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_idx;

  int checks   = 0;
  int failures = 0;

  sprite_line_fetch_if rom_bus ();

  always #5 clk = ~clk;

  always @(posedge clk) rom_bus.rom_q <= rom_bus.rom_addr[2:0];

  sprite_line_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_start (line_start),
    .next_y     (next_y),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
`ifdef SPRITE_FLIP_EN
    .flip       (flip),
`endif
    .draw_x     (draw_x),
    .rom        (rom_bus),
    .busy       (busy),
    .pix_valid  (pix_valid),
    .pix_idx    (pix_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int ny);
    next_y     = 10'(ny);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Expected palette index at screen column x for a row whose first ROM address is base.
  function automatic logic [2:0] exp_idx(input int x, input int sx, input int base,
                                         input bit flipped);
    int d;
    int c;
    d = x - sx;
    if (d < 0 || d >= 26) return 3'd0;
    c = flipped ? (25 - d) : d;
    return 3'(base + c);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (pix_valid !== 1'b0) begin
      failures++; $display("FAIL reset_pix_valid got=%b want=0", pix_valid);
    end
    if (pix_idx !== 3'd0) begin failures++; $display("FAIL reset_pix_idx got=%0d want=0", pix_idx); end
    if (rom_bus.rom_addr !== 10'd0) begin
      failures++; $display("FAIL reset_rom_addr got=%0d want=0", rom_bus.rom_addr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int n;
    draw_x = 10'd205;
    start_line(105);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      if (n < 26) begin
        checks++;
        if (rom_bus.rom_addr !== 10'(130 + n)) begin
          failures++;
          $display("FAIL fetch_addr cycle=%0d got=%0d want=%0d", n, rom_bus.rom_addr, 130 + n);
        end
      end
      checks++;
      if (pix_valid !== 1'b0) begin
        failures++; $display("FAIL fetch_pix_hidden cycle=%0d got=%b want=0", n, pix_valid);
      end
      n++;
      tick();
    end
    checks += 2;
    if (n != 27) begin failures++; $display("FAIL fetch_busy_len got=%0d want=27", n); end
    if (rom_bus.rom_addr !== 10'd155) begin
      failures++; $display("FAIL fetch_addr_hold got=%0d want=155", rom_bus.rom_addr);
    end
  endtask

  task automatic test_pixels();
    logic [2:0] e;
    for (int x = 199; x <= 226; x++) begin
      draw_x = 10'(x);
      tick();
      e = exp_idx(x, 200, 130, 1'b0);
      checks += 2;
      if (pix_idx !== e) begin
        failures++; $display("FAIL pix_idx x=%0d got=%0d want=%0d", x, pix_idx, e);
      end
      if (pix_valid !== (e != 3'd0)) begin
        failures++; $display("FAIL pix_valid x=%0d got=%b want=%b", x, pix_valid, e != 3'd0);
      end
    end
  endtask

  task automatic test_reject();
    int rows [2] = '{99, 132};
    for (int r = 0; r < 2; r++) begin
      start_line(rows[r]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++; $display("FAIL reject_busy y=%0d got=%b want=0", rows[r], busy);
        end
        tick();
      end
      for (int x = 199; x <= 226; x++) begin
        draw_x = 10'(x);
        tick();
        checks++;
        if (pix_valid !== 1'b0 || pix_idx !== 3'd0) begin
          failures++;
          $display("FAIL reject_pix y=%0d x=%0d got=%b/%0d want=0/0", rows[r], x, pix_valid,
                   pix_idx);
        end
      end
    end
  endtask

  task automatic test_ignore_restart();
    int n;
    start_line(105);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      if (n == 10) begin
        next_y     = 10'd110;
        line_start = 1'b1;
      end else begin
        line_start = 1'b0;
      end
      if (n < 26) begin
        checks++;
        if (rom_bus.rom_addr !== 10'(130 + n)) begin
          failures++;
          $display("FAIL ignore_addr cycle=%0d got=%0d want=%0d", n, rom_bus.rom_addr, 130 + n);
        end
      end
      n++;
      tick();
    end
    line_start = 1'b0;
    checks++;
    if (n != 27) begin failures++; $display("FAIL ignore_busy_len got=%0d want=27", n); end
    draw_x = 10'd205;
    tick();
    checks++;
    if (pix_idx !== 3'd7 || pix_valid !== 1'b1) begin
      failures++; $display("FAIL ignore_row_kept got=%b/%0d want=1/7", pix_valid, pix_idx);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    draw_x = 10'd205;
    start_line(105);
    for (int k = 0; k < 5; k++) tick();
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", busy); end
    if (pix_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_pix_valid got=%b want=0", pix_valid);
    end
    if (rom_bus.rom_addr !== 10'd0) begin
      failures++; $display("FAIL midreset_addr got=%0d want=0", rom_bus.rom_addr);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_idle got=%b/%b want=0/0", busy, pix_valid);
    end
    start_line(105);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      if (n < 26) begin
        checks++;
        if (rom_bus.rom_addr !== 10'(130 + n)) begin
          failures++;
          $display("FAIL midreset_addr cycle=%0d got=%0d want=%0d", n, rom_bus.rom_addr, 130 + n);
        end
      end
      n++;
      tick();
    end
    checks++;
    if (n != 27) begin failures++; $display("FAIL midreset_busy_len got=%0d want=27", n); end
    for (int x = 199; x <= 226; x++) begin
      draw_x = 10'(x);
      tick();
      checks++;
      if (pix_idx !== exp_idx(x, 200, 130, 1'b0)) begin
        failures++;
        $display("FAIL midreset_pix x=%0d got=%0d want=%0d", x, pix_idx,
                 exp_idx(x, 200, 130, 1'b0));
      end
    end
  endtask

  task automatic test_last_row();
    int n;
    start_line(131);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      if (n == 0 || n == 25) begin
        checks++;
        if (rom_bus.rom_addr !== 10'(806 + n)) begin
          failures++;
          $display("FAIL lastrow_addr cycle=%0d got=%0d want=%0d", n, rom_bus.rom_addr, 806 + n);
        end
      end
      n++;
      tick();
    end
    checks++;
    if (n != 27) begin failures++; $display("FAIL lastrow_busy_len got=%0d want=27", n); end
    draw_x = 10'd200;
    tick();
    checks++;
    if (pix_idx !== 3'd6 || pix_valid !== 1'b1) begin
      failures++; $display("FAIL lastrow_pix got=%b/%0d want=1/6", pix_valid, pix_idx);
    end
  endtask

`ifdef SPRITE_FLIP_EN
  task automatic test_flip();
    int n;
    flip = 1'b1;
    start_line(105);
    flip = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    checks++;
    if (n != 27) begin failures++; $display("FAIL flip_busy_len got=%0d want=27", n); end
    for (int x = 199; x <= 226; x++) begin
      draw_x = 10'(x);
      tick();
      checks++;
      if (pix_idx !== exp_idx(x, 200, 130, 1'b1)) begin
        failures++;
        $display("FAIL flip_pix x=%0d got=%0d want=%0d", x, pix_idx, exp_idx(x, 200, 130, 1'b1));
      end
    end
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    line_start = 1'b0;
    next_y     = 10'd0;
    spr_x      = 10'd200;
    spr_y      = 10'd100;
    flip       = 1'b0;
    draw_x     = 10'd0;
    test_reset();
    test_fetch();
    test_pixels();
    test_reject();
    test_ignore_restart();
    test_reset_mid();
    test_last_row();
`ifdef SPRITE_FLIP_EN
    test_flip();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
